// File: rtl/memory_access.sv
// rtl/memory_access.sv - MIPS MEM stage: byte/half/word loads and stores against an internal data RAM
//
// Purpose:
//   Consumes the registered EX-stage outputs (ALU result used as a byte
//   address, forwarded store data and the MEM/WB control bits).
//   Performs little-endian byte, half-word and word loads/stores against a
//   2^NB_ADDR x NB_DATA data RAM and registers the results toward WB.
//   A read-only debug port returns a registered RAM word every cycle, even
//   while the pipeline is frozen.
//
// Ports:
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_enable                 1 = pipeline advances, 0 = registers and RAM hold
//   i_WB_write               instruction writes the register bank
//   i_WB_mem_to_reg          WB source select, passed through
//   i_MEM_read/i_MEM_write   load / store
//   i_MEM_unsigned           1 = zero-extend sub-word loads
//   i_MEM_byte_half_word     00 byte, 01 half, 1x word
//   i_write_reg              destination register, passed through
//   i_ALU_result             byte address / pass-through result
//   i_data_to_write_in_MEM   store data
//   i_debug_addr             debug word address
//   o_WB_write               registered, cleared on a misaligned access
//   o_WB_mem_to_reg          registered
//   o_write_reg              registered
//   o_ALU_result             registered
//   o_mem_data               registered extended load data (0 when no load)
//   o_misaligned             registered misaligned-access flag
//   o_debug_data             registered RAM word at i_debug_addr
module memory_access #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_WB_write,
  input  logic               i_WB_mem_to_reg,
  input  logic               i_MEM_read,
  input  logic               i_MEM_write,
  input  logic               i_MEM_unsigned,
  input  logic [1:0]         i_MEM_byte_half_word,
  input  logic [4:0]         i_write_reg,
  input  logic [NB_DATA-1:0] i_ALU_result,
  input  logic [NB_DATA-1:0] i_data_to_write_in_MEM,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic               o_WB_write,
  output logic               o_WB_mem_to_reg,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_ALU_result,
  output logic [NB_DATA-1:0] o_mem_data,
  output logic               o_misaligned,
  output logic [NB_DATA-1:0] o_debug_data
);

  localparam int N_WORDS = 2 ** NB_ADDR;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  // Data RAM; intentionally not reset.
  logic [NB_DATA-1:0] ram_q [N_WORDS];

  // Address decode. Bits above NB_ADDR+1 are ignored so addresses wrap.
  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         byte_off;
  logic               is_byte;
  logic               is_half;
  logic               addr_misaligned;
  logic               misaligned;

  assign word_idx = i_ALU_result[NB_ADDR+1:2];
  assign byte_off = i_ALU_result[1:0];
  assign is_byte  = (i_MEM_byte_half_word == SIZE_BYTE);
  assign is_half  = (i_MEM_byte_half_word == SIZE_HALF);

  // Encoding 10 falls through to the word rule.
  always_comb begin
    addr_misaligned = 1'b0;
    if (is_byte) begin
      addr_misaligned = 1'b0;
    end else if (is_half) begin
      addr_misaligned = byte_off[0];
    end else begin
      addr_misaligned = |byte_off;
    end
  end

  // Only an actual memory access can be misaligned; pass-through ops never flag.
  assign misaligned = (i_MEM_read | i_MEM_write) & addr_misaligned;

  // Asynchronous read of the addressed word. Loads see the contents before
  // this cycle's store lands, giving read-first behaviour on read+write.
  logic [NB_DATA-1:0] ram_rd_word;
  logic [NB_DATA-1:0] lane_shifted;
  logic [NB_DATA-1:0] load_ext;

  assign ram_rd_word  = ram_q[word_idx];
  assign lane_shifted = ram_rd_word >> {byte_off, 3'b000};

  always_comb begin
    load_ext = '0;
    if (is_byte) begin
      load_ext = {{(NB_DATA-8){~i_MEM_unsigned & lane_shifted[7]}}, lane_shifted[7:0]};
    end else if (is_half) begin
      load_ext = {{(NB_DATA-16){~i_MEM_unsigned & lane_shifted[15]}}, lane_shifted[15:0]};
    end else begin
      load_ext = ram_rd_word;
    end
  end

  // Store path: merge the new lanes into the current word and write it whole.
  logic [NB_DATA-1:0] ram_word_d;
  logic               ram_we;

  always_comb begin
    ram_word_d = ram_rd_word;
    if (is_byte) begin
      ram_word_d[{byte_off, 3'b000} +: 8] = i_data_to_write_in_MEM[7:0];
    end else if (is_half) begin
      ram_word_d[{byte_off[1], 4'b0000} +: 16] = i_data_to_write_in_MEM[15:0];
    end else begin
      ram_word_d = i_data_to_write_in_MEM;
    end
  end

  // Gating with i_reset_n keeps an edge that coincides with reset from storing.
  assign ram_we = i_reset_n & i_enable & i_MEM_write & ~misaligned;

  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      ram_q[word_idx] <= ram_word_d;
    end
  end

  // WB-side pipeline registers.
  logic               wb_write_q,      wb_write_d;
  logic               wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [4:0]         write_reg_q,     write_reg_d;
  logic [NB_DATA-1:0] alu_result_q,    alu_result_d;
  logic [NB_DATA-1:0] mem_data_q,      mem_data_d;
  logic               misaligned_q,    misaligned_d;
  logic [NB_DATA-1:0] debug_data_q,    debug_data_d;

  always_comb begin
    wb_write_d      = wb_write_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    write_reg_d     = write_reg_q;
    alu_result_d    = alu_result_q;
    mem_data_d      = mem_data_q;
    misaligned_d    = misaligned_q;
    if (i_enable) begin
      wb_write_d      = i_WB_write & ~misaligned;
      wb_mem_to_reg_d = i_WB_mem_to_reg;
      write_reg_d     = i_write_reg;
      alu_result_d    = i_ALU_result;
      mem_data_d      = (i_MEM_read & ~misaligned) ? load_ext : '0;
      misaligned_d    = misaligned;
    end
    // Debug port keeps running while the pipeline is frozen.
    debug_data_d = ram_q[i_debug_addr];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb_write_q      <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      write_reg_q     <= '0;
      alu_result_q    <= '0;
      mem_data_q      <= '0;
      misaligned_q    <= 1'b0;
      debug_data_q    <= '0;
    end else begin
      wb_write_q      <= wb_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      write_reg_q     <= write_reg_d;
      alu_result_q    <= alu_result_d;
      mem_data_q      <= mem_data_d;
      misaligned_q    <= misaligned_d;
      debug_data_q    <= debug_data_d;
    end
  end

  assign o_WB_write      = wb_write_q;
  assign o_WB_mem_to_reg = wb_mem_to_reg_q;
  assign o_write_reg     = write_reg_q;
  assign o_ALU_result    = alu_result_q;
  assign o_mem_data      = mem_data_q;
  assign o_misaligned    = misaligned_q;
  assign o_debug_data    = debug_data_q;

endmodule
